// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider: one quotient bit per clock, sign fix-up
// in a final cycle, then a one-cycle done pulse with quotient, remainder and flags.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] di,
  input  logic [WIDTH-1:0] bi,
  input  logic [7:0]       fi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic [7:0]       fo,
  output logic             div0
);

  localparam int CIDX  = 0;
  localparam int VIDX  = 1;
  localparam int ZIDX  = 2;
  localparam int SIDX  = 3;
  localparam int PIDX  = 4;
  localparam int UIDX  = 5;
  localparam int N1IDX = 6;
  localparam int N2IDX = 7;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_ONLY  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W    = {WIDTH{1'b0}};
  localparam logic [7:0]       KEEP_MASK = (8'd1 << PIDX) | (8'd1 << UIDX) |
                                           (8'd1 << N1IDX) | (8'd1 << N2IDX);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] x);
    return ~x + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // Arithmetic flags overlay the pass-through bits already masked from fi.
  function automatic logic [7:0] make_flags(input logic [WIDTH-1:0] q,
                                            input logic [WIDTH-1:0] r,
                                            input logic             v,
                                            input logic [7:0]       keep);
    logic [7:0] f;
    f       = keep;
    f[ZIDX] = (q == ZERO_W);
    f[SIDX] = q[WIDTH-1];
    f[CIDX] = (r != ZERO_W);
    f[VIDX] = v;
    return f;
  endfunction

  state_e           state_q, state_d;
  logic             sgn_q, sgn_d;
  logic             dneg_q, dneg_d;
  logic             bneg_q, bneg_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       fkeep_q, fkeep_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [7:0]       fo_q, fo_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   trial_s;
  logic [WIDTH:0]   diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] qfix_s;
  logic [WIDTH-1:0] rfix_s;

  // Next-state and datapath for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    state_d = state_q;
    sgn_d   = sgn_q;
    dneg_d  = dneg_q;
    bneg_d  = bneg_q;
    ovf_d   = ovf_q;
    fkeep_d = fkeep_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    fo_d    = fo_q;
    div0_d  = div0_q;
    trial_s = {prem_q, dvd_q[WIDTH-1]};
    diff_s  = trial_s - {1'b0, dvs_q};
    qbit_s  = 1'b0;
    qfix_s  = dvd_q;
    rfix_s  = prem_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sgn_d   = sgn;
          dneg_d  = di[WIDTH-1];
          bneg_d  = bi[WIDTH-1];
          ovf_d   = sgn && (di == MSB_ONLY) && (bi == ALL_ONES);
          fkeep_d = fi & KEEP_MASK;
          dvd_d   = (sgn && di[WIDTH-1]) ? neg2c(di) : di;
          dvs_d   = (sgn && bi[WIDTH-1]) ? neg2c(bi) : bi;
          if (bi == ZERO_W) begin
            quo_d   = ALL_ONES;
            rem_d   = di;
            div0_d  = 1'b1;
            fo_d    = make_flags(ALL_ONES, di, 1'b1, fi & KEEP_MASK);
            state_d = S_DONE;
          end else begin
            div0_d  = 1'b0;
            prem_d  = ZERO_W;
            cnt_d   = CNT_LAST;
            state_d = S_CALC;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        // A clear borrow bit means the trial covers the divisor magnitude.
        if (!diff_s[WIDTH]) begin
          prem_d = diff_s[WIDTH-1:0];
          qbit_s = 1'b1;
        end else begin
          prem_d = trial_s[WIDTH-1:0];
          qbit_s = 1'b0;
        end
        dvd_d = {dvd_q[WIDTH-2:0], qbit_s};
        cnt_d = cnt_q - {{(CW-1){1'b0}}, 1'b1};
        if (cnt_q == {CW{1'b0}}) begin
          state_d = S_FIX;
        end else begin
          state_d = S_CALC;
        end
      end
      S_FIX: begin
        if (sgn_q && (dneg_q != bneg_q)) begin
          qfix_s = neg2c(dvd_q);
        end else begin
          qfix_s = dvd_q;
        end
        if (sgn_q && dneg_q) begin
          rfix_s = neg2c(prem_q);
        end else begin
          rfix_s = prem_q;
        end
        quo_d   = qfix_s;
        rem_d   = rfix_s;
        fo_d    = make_flags(qfix_s, rfix_s, ovf_q, fkeep_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      sgn_q   <= 1'b0;
      dneg_q  <= 1'b0;
      bneg_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fkeep_q <= 8'h00;
      dvd_q   <= ZERO_W;
      dvs_q   <= ZERO_W;
      prem_q  <= ZERO_W;
      cnt_q   <= {CW{1'b0}};
      quo_q   <= ZERO_W;
      rem_q   <= ZERO_W;
      fo_q    <= 8'h00;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      dneg_q  <= dneg_d;
      bneg_q  <= bneg_d;
      ovf_q   <= ovf_d;
      fkeep_q <= fkeep_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      fo_q    <= fo_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign fo   = fo_q;
  assign div0 = div0_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed divisions checked against literal results and
// against a plain-arithmetic model compared on every falling clock edge.
module tb_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] di = '0;
  logic [W-1:0] bi = '0;
  logic [7:0]   fi = 8'h00;
  logic         busy, done, div0;
  logic [W-1:0] quo, rem;
  logic [7:0]   fo;

  div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sgn(sgn),
    .di(di), .bi(bi), .fi(fi),
    .busy(busy), .done(done), .quo(quo), .rem(rem), .fo(fo), .div0(div0)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Model: the single accepted operation in flight and the values the outputs hold.
  bit           op_valid = 1'b0;
  int           op_e0 = 0;
  int           op_done = 0;
  int           acc_e0 = 0;
  logic [W-1:0] op_quo, op_rem;
  logic [7:0]   op_fo;
  logic         op_div0;
  logic [W-1:0] h_quo = '0;
  logic [W-1:0] h_rem = '0;
  logic [7:0]   h_fo = 8'h00;
  logic         h_div0 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a rising edge; start is sampled at the next edge.
  task automatic issue(input logic s, input logic [W-1:0] d, input logic [W-1:0] b,
                       input logic [7:0] f);
    int           e0;
    longint       a, bb;
    logic [W-1:0] q, r;
    logic         v;
    start = 1'b1; sgn = s; di = d; bi = b; fi = f;
    e0 = cyc + 1;
    if (!op_valid || e0 >= op_done + 2) begin
      if (b == '0) begin
        q = {W{1'b1}}; r = d; v = 1'b1;
      end else if (s) begin
        a = longint'($signed(d)); bb = longint'($signed(b));
        q = W'(a / bb); r = W'(a % bb);
        v = (d == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      end else begin
        a = longint'({32'd0, d}); bb = longint'({32'd0, b});
        q = W'(a / bb); r = W'(a % bb); v = 1'b0;
      end
      op_quo  = q;
      op_rem  = r;
      op_div0 = (b == '0);
      op_fo   = {f[7:4], q[W-1], (q == '0), v, (r != '0)};
      op_e0   = e0;
      op_done = e0 + ((b == '0) ? 0 : W + 1);
      op_valid = 1'b1;
      acc_e0  = e0;
    end
    @(posedge clk); #1;
    start = 1'b0; sgn = 1'($urandom); di = $urandom; bi = $urandom; fi = 8'($urandom);
  endtask

  task automatic wait_done(output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 80 cycles");
    end else begin
      lat = cyc - acc_e0 + 1;
    end
  endtask

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic exp_busy, exp_done;
    exp_busy = op_valid && (cyc >= op_e0) && (cyc <= op_done);
    exp_done = op_valid && (cyc == op_done);
    if (op_valid && cyc == op_e0) h_div0 = op_div0;
    if (exp_done) begin
      h_quo = op_quo; h_rem = op_rem; h_fo = op_fo;
    end
    check("busy", busy, exp_busy);
    check("done", done, exp_done);
    check("quo", quo, h_quo);
    check("rem", rem, h_rem);
    check("fo", fo, h_fo);
    check("div0", div0, h_div0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", busy, 1'b0);
    check("reset quo", quo, 32'h0);
    check("reset fo", fo, 8'h00);
    reset_n = 1'b1;
    @(posedge clk); #1;

    issue(1'b0, 32'd100, 32'd7, 8'h00);
    wait_done(lat);
    check("u100/7 lat", lat, 34);
    check("u100/7 quo", quo, 32'd14);
    check("u100/7 rem", rem, 32'd2);
    check("u100/7 fo", fo, 8'h01);
    check("u100/7 div0", div0, 1'b0);
    @(posedge clk); #1;

    issue(1'b1, 32'hFFFF_FF9C, 32'd7, 8'h00);
    wait_done(lat);
    check("s-100/7 lat", lat, 34);
    check("s-100/7 quo", quo, 32'hFFFF_FFF2);
    check("s-100/7 rem", rem, 32'hFFFF_FFFE);
    check("s-100/7 fo", fo, 8'h09);
    @(posedge clk); #1;

    issue(1'b1, 32'd100, 32'hFFFF_FFF9, 8'h00);
    wait_done(lat);
    check("s100/-7 quo", quo, 32'hFFFF_FFF2);
    check("s100/-7 rem", rem, 32'd2);
    check("s100/-7 fo", fo, 8'h09);
    @(posedge clk); #1;

    issue(1'b0, 32'h1234, 32'h0, 8'hF0);
    wait_done(lat);
    check("div0 lat", lat, 1);
    check("div0 quo", quo, 32'hFFFF_FFFF);
    check("div0 rem", rem, 32'h1234);
    check("div0 flag", div0, 1'b1);
    check("div0 fo", fo, 8'hFB);
    @(posedge clk); #1;

    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00);
    wait_done(lat);
    check("sovf quo", quo, 32'h8000_0000);
    check("sovf rem", rem, 32'h0);
    check("sovf fo", fo, 8'h0A);
    check("sovf div0", div0, 1'b0);
    @(posedge clk); #1;

    issue(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 8'h00);
    wait_done(lat);
    check("uovf quo", quo, 32'h0);
    check("uovf rem", rem, 32'h8000_0000);
    check("uovf fo", fo, 8'h05);
    @(posedge clk); #1;

    issue(1'b0, 32'd50, 32'd5, 8'h00);
    repeat (9) @(posedge clk);
    #1;
    issue(1'b0, 32'd9, 32'd3, 8'h00);
    wait_done(lat);
    check("busy-ign lat", lat, 34);
    check("busy-ign quo", quo, 32'd10);
    check("busy-ign rem", rem, 32'd0);
    check("busy-ign fo", fo, 8'h00);
    @(posedge clk); #1;

    issue(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 8'hA5);
    wait_done(lat);
    check("s-7/-2 quo", quo, 32'd3);
    check("s-7/-2 rem", rem, 32'hFFFF_FFFF);
    check("s-7/-2 fo", fo, 8'hA1);
    @(posedge clk); #1;

    issue(1'b1, 32'hFFFF_FF00, 32'h0, 8'h00);
    wait_done(lat);
    check("sdiv0 rem", rem, 32'hFFFF_FF00);
    check("sdiv0 fo", fo, 8'h0B);
    @(posedge clk); #1;

    issue(1'b0, 32'd1000, 32'd3, 8'h00);
    repeat (14) @(posedge clk);
    #1;
    reset_n = 1'b0;
    op_valid = 1'b0;
    h_quo = '0; h_rem = '0; h_fo = 8'h00; h_div0 = 1'b0;
    #1;
    check("abort busy", busy, 1'b0);
    check("abort quo", quo, 32'h0);
    check("abort fo", fo, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    issue(1'b0, 32'd7, 32'd2, 8'h00);
    wait_done(lat);
    check("post-rst quo", quo, 32'd3);
    check("post-rst rem", rem, 32'd1);
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      issue(1'($urandom), $urandom, (k % 3 == 0) ? 32'($urandom_range(1, 9)) : $urandom,
            8'($urandom));
      wait_done(lat);
      check("rand lat", lat, 34);
      @(posedge clk); #1;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
